// File: rtl/tdm_demux.sv
// TDM receive demux: locks onto frame start and collects one beat per slot.
// Each complete frame is presented in parallel with a one-cycle strobe.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-low
//   in_valid  in_data/in_sof qualify this cycle
//   in_data   slot sample
//   in_sof    beat is slot 0 of a frame
//   out_data  last complete frame; channel k at [k*DATA_W +: DATA_W]
//   out_valid 1-cycle pulse: out_data holds a new frame
//   locked    1 while collecting frames
//   slot_idx  next slot expected (0 while hunting)
//   sync_err  1-cycle pulse on a framing violation
module tdm_demux #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  localparam int SW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_sof,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic                   out_valid,
  output logic                   locked,
  output logic [SW-1:0]          slot_idx,
  output logic                   sync_err
);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

  state_t  state_q;
  state_t  state_d;
  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  // Slots 0..N_CH-2 are buffered here; the last slot goes
  // straight into out_data together with them.
  logic [N_CH-2:0][DATA_W-1:0] shadow_q;

  logic [N_CH*DATA_W-1:0] out_data_q;
  logic                   out_valid_q;
  logic                   sync_err_q;

  logic          sh_we;
  logic [SW-1:0] sh_idx;
  logic          done;
  logic          err;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh_we   = 1'b0;
    sh_idx  = '0;
    done    = 1'b0;
    err     = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_sof) begin
            sh_we   = 1'b1;
            slot_d  = SW'(1);
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          unique case (1'b1)
            in_sof: begin
              // early SOF drops the partial frame and restarts it
              err    = (slot_q != '0);
              sh_we  = 1'b1;
              slot_d = SW'(1);
            end
            (!in_sof && slot_q == '0): begin
              err     = 1'b1;
              slot_d  = '0;
              state_d = HUNT;
            end
            (!in_sof && slot_q == LAST): begin
              done   = 1'b1;
              slot_d = '0;
            end
            default: begin
              sh_we  = 1'b1;
              sh_idx = slot_q;
              slot_d = slot_q + SW'(1);
            end
          endcase
        end
        default: begin
          state_d = HUNT;
          slot_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
    end else begin
      for (int k = 0; k < N_CH - 1; k++) begin
        if (sh_we && sh_idx == SW'(k)) begin
          shadow_q[k] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      out_valid_q <= done;
      sync_err_q  <= err;
      if (done) begin
        out_data_q <= {in_data, shadow_q};
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign locked    = (state_q == COLLECT);
  assign slot_idx  = slot_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frame scenarios plus random
// traffic checked against a queue-based frame model.
module tb_tdm_demux;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_sof;
  logic [W-1:0]   in_data;
  logic [N*W-1:0] out_data;
  logic           out_valid;
  logic           locked;
  logic [SW-1:0]  slot_idx;
  logic           sync_err;

  tdm_demux #(.N_CH(N), .DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .out_data (out_data),
    .out_valid(out_valid),
    .locked   (locked),
    .slot_idx (slot_idx),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_vld = 0;

  bit             m_lock;
  logic [W-1:0]   m_part[$];
  logic [N*W-1:0] m_frame;
  bit             m_valid;
  bit             m_err;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_lock  = 1'b0;
    m_part.delete();
    m_frame = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endfunction

  // Frame-level model: the collected beats of the current frame
  // live in a queue; its length is the next expected slot.
  function automatic void m_step(bit v, bit s, logic [W-1:0] d);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!v) return;
    if (!m_lock) begin
      if (s) begin
        m_part = {d};
        m_lock = 1'b1;
      end
    end else if (s) begin
      m_err  = (m_part.size() != 0);
      m_part = {d};
    end else if (m_part.size() == 0) begin
      m_err  = 1'b1;
      m_lock = 1'b0;
    end else begin
      m_part.push_back(d);
      if (m_part.size() == N) begin
        for (int k = 0; k < N; k++) m_frame[k*W +: W] = m_part[k];
        m_valid = 1'b1;
        m_part.delete();
      end
    end
  endfunction

  task automatic check_all(string tag);
    int exp_slot;
    exp_slot = m_lock ? m_part.size() : 0;
    chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".err"},   64'(sync_err),  64'(m_err));
    chk({tag, ".lock"},  64'(locked),    64'(m_lock));
    chk({tag, ".slot"},  64'(slot_idx),  64'(exp_slot));
    chk({tag, ".data"},  64'(out_data),  64'(m_frame));
  endtask

  task automatic cycle(string tag, bit v, bit s, logic [W-1:0] d);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    m_step(v, s, d);
    @(posedge clk);
    #1;
    if (out_valid) n_vld++;
    check_all(tag);
  endtask

  task automatic gap(int n);
    for (int i = 0; i < n; i++) cycle("gap", 1'b0, 1'b0, W'($urandom));
  endtask

  task automatic frame4(string tag, int max_gap);
    cycle(tag, 1'b1, 1'b1, 8'h11);
    gap($urandom_range(max_gap));
    cycle(tag, 1'b1, 1'b0, 8'h22);
    gap($urandom_range(max_gap));
    cycle(tag, 1'b1, 1'b0, 8'h33);
    gap($urandom_range(max_gap));
    cycle(tag, 1'b1, 1'b0, 8'h44);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    m_reset();
    #12;
    chk("rst.data",  64'(out_data),  64'h0);
    chk("rst.valid", 64'(out_valid), 64'h0);
    chk("rst.lock",  64'(locked),    64'h0);
    chk("rst.slot",  64'(slot_idx),  64'h0);
    chk("rst.err",   64'(sync_err),  64'h0);
    @(negedge clk);
    rst = 1'b1;

    frame4("t2", 0);
    chk("t2.valid", 64'(out_valid), 64'h1);
    chk("t2.data",  64'(out_data),  64'h44332211);
    chk("t2.slot",  64'(slot_idx),  64'h0);
    chk("t2.lock",  64'(locked),    64'h1);
    cycle("t2.after", 1'b0, 1'b0, 8'h00);
    chk("t2.pulse", 64'(out_valid), 64'h0);

    for (int r = 0; r < 3; r++) begin
      n_vld = 0;
      frame4("t3", 3);
      chk("t3.valid", 64'(out_valid), 64'h1);
      chk("t3.data",  64'(out_data),  64'h44332211);
      gap(2);
      chk("t3.once", 64'(n_vld), 64'h1);
    end

    n_vld = 0;
    cycle("t5", 1'b1, 1'b1, 8'h11);
    cycle("t5", 1'b1, 1'b0, 8'h22);
    cycle("t5", 1'b1, 1'b1, 8'hAA);
    chk("t5.err",  64'(sync_err), 64'h1);
    chk("t5.lock", 64'(locked),   64'h1);
    cycle("t5", 1'b1, 1'b0, 8'hBB);
    chk("t5.errpulse", 64'(sync_err), 64'h0);
    cycle("t5", 1'b1, 1'b0, 8'hCC);
    cycle("t5", 1'b1, 1'b0, 8'hDD);
    chk("t5.valid", 64'(out_valid), 64'h1);
    chk("t5.data",  64'(out_data),  64'hDDCCBBAA);
    chk("t5.once",  64'(n_vld),     64'h1);

    cycle("t6", 1'b1, 1'b0, 8'h77);
    chk("t6.err",  64'(sync_err), 64'h1);
    chk("t6.lock", 64'(locked),   64'h0);
    chk("t6.data", 64'(out_data), 64'hDDCCBBAA);

    n_vld = 0;
    cycle("t4", 1'b1, 1'b0, 8'h55);
    chk("t4.err0", 64'(sync_err), 64'h0);
    cycle("t4", 1'b1, 1'b0, 8'h66);
    chk("t4.err1", 64'(sync_err), 64'h0);
    frame4("t4", 0);
    chk("t4.data", 64'(out_data), 64'h44332211);
    chk("t4.once", 64'(n_vld),    64'h1);

    for (int i = 0; i < 2000; i++) begin
      bit v;
      bit s;
      int want0;
      want0 = !m_lock || m_part.size() == 0;
      v = ($urandom_range(99) < 75);
      s = want0 ? ($urandom_range(99) < 85) : ($urandom_range(99) < 5);
      cycle("rnd", v, s, W'($urandom));
      if (i == 1000) begin
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t1.data",  64'(out_data),  64'h0);
        chk("t1.valid", 64'(out_valid), 64'h0);
        chk("t1.lock",  64'(locked),    64'h0);
        chk("t1.slot",  64'(slot_idx),  64'h0);
        chk("t1.err",   64'(sync_err),  64'h0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
